// File: rtl/stim_scheduler_pkg.sv
// Shared types and helpers for the stimulation scheduler: state encoding,
// counter width helper and history popcount.
package stim_pkg;

    localparam int unsigned STATE_W     = 3;
    localparam int unsigned TRAIN_CNT_W = 16;

    typedef enum logic [STATE_W-1:0] {
        WARMUP  = 3'd0,
        IDLE    = 3'd1,
        STIM_HI = 3'd2,
        STIM_LO = 3'd3,
        REFRACT = 3'd4
    } state_e;

    // Bits needed to hold the values 0..max_val (at least one bit).
    function automatic int unsigned width_for(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/stim_scheduler_pulse_train_gen.sv
// Pulse train sequencer: NUM_PULSES pulses of PULSE_HI high / PULSE_LO low cycles.
// pulse_o is the pulse level for the next cycle; done_o flags the final low cycle.
module pulse_train_gen
    import stim_pkg::*;
#(
    parameter int unsigned PULSE_HI   = 4,
    parameter int unsigned PULSE_LO   = 6,
    parameter int unsigned NUM_PULSES = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic abort_i,
    output logic pulse_o,
    output logic done_o
);

    localparam int unsigned CW = width_for((PULSE_HI > PULSE_LO) ? PULSE_HI : PULSE_LO);
    localparam int unsigned PW = width_for(NUM_PULSES);
    localparam logic [CW-1:0] HI_LAST  = CW'(PULSE_HI - 1);
    localparam logic [CW-1:0] LO_LAST  = CW'(PULSE_LO - 1);
    localparam logic [PW-1:0] PLS_LAST = PW'(NUM_PULSES);

    logic          active_q, active_d;
    logic          hi_q, hi_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [PW-1:0] pls_q, pls_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            active_q <= 1'b0;
            hi_q     <= 1'b0;
            cyc_q    <= '0;
            pls_q    <= '0;
        end else begin
            active_q <= active_d;
            hi_q     <= hi_d;
            cyc_q    <= cyc_d;
            pls_q    <= pls_d;
        end
    end

    always_comb begin
        active_d = active_q;
        hi_d     = hi_q;
        cyc_d    = cyc_q;
        pls_d    = pls_q;
        done_o   = 1'b0;
        if (abort_i) begin
            active_d = 1'b0;
            hi_d     = 1'b0;
            cyc_d    = '0;
        end else if (start_i) begin
            active_d = 1'b1;
            hi_d     = 1'b1;
            cyc_d    = '0;
            pls_d    = PW'(1);
        end else if (active_q) begin
            if (hi_q) begin
                if (cyc_q == HI_LAST) begin
                    hi_d  = 1'b0;
                    cyc_d = '0;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end else if (cyc_q == LO_LAST) begin
                cyc_d = '0;
                if (pls_q < PLS_LAST) begin
                    pls_d = pls_q + 1'b1;
                    hi_d  = 1'b1;
                end else begin
                    active_d = 1'b0;
                    done_o   = 1'b1;
                end
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
        end
        pulse_o = active_d & hi_d;
    end

endmodule

// File: rtl/stim_scheduler.sv
// Closed-loop stimulation controller: K-of-M window vote after a warm-up,
// then a pulse train followed by a refractory period. en is active-low.
module stim_scheduler
    import stim_pkg::*;
#(
    parameter int unsigned SUM_W       = 12,
    parameter int          THRESHOLD   = 300,
    parameter int unsigned M_WIN       = 4,
    parameter int unsigned K_HITS      = 3,
    parameter int unsigned WARMUP_WIN  = 8,
    parameter int unsigned PULSE_HI    = 4,
    parameter int unsigned PULSE_LO    = 6,
    parameter int unsigned NUM_PULSES  = 3,
    parameter int unsigned REFRACT_WIN = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   win_valid,
    input  logic [SUM_W-1:0]       ws_in,
    output logic                   stimulation,
    output logic                   busy,
    output logic [STATE_W-1:0]     state_out,
    output logic [3:0]             hit_count,
    output logic [TRAIN_CNT_W-1:0] train_count
);

    localparam int unsigned WCW = width_for((WARMUP_WIN > REFRACT_WIN) ? WARMUP_WIN : REFRACT_WIN);
    localparam logic [WCW-1:0] WARM_LAST = WCW'((WARMUP_WIN  == 0) ? 0 : WARMUP_WIN  - 1);
    localparam logic [WCW-1:0] REFR_LAST = WCW'((REFRACT_WIN == 0) ? 0 : REFRACT_WIN - 1);
    localparam logic signed [SUM_W-1:0] THR = SUM_W'(THRESHOLD);

    state_e                 state_q, state_d;
    logic [M_WIN-1:0]       hist_q, hist_d;
    logic [WCW-1:0]         win_q, win_d;
    logic [TRAIN_CNT_W-1:0] train_q, train_d;
    logic                   stim_q, busy_q;
    logic [3:0]             hitc_q;

    logic                   strobe;
    logic                   hit;
    logic [M_WIN-1:0]       hist_new;
    logic                   gen_start, gen_abort, gen_pulse, gen_done;

    pulse_train_gen #(
        .PULSE_HI   (PULSE_HI),
        .PULSE_LO   (PULSE_LO),
        .NUM_PULSES (NUM_PULSES)
    ) u_train (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (gen_start),
        .abort_i (gen_abort),
        .pulse_o (gen_pulse),
        .done_o  (gen_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WARMUP;
            hist_q  <= '0;
            win_q   <= '0;
            train_q <= '0;
            stim_q  <= 1'b0;
            busy_q  <= 1'b0;
            hitc_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            win_q   <= win_d;
            train_q <= train_d;
            stim_q  <= (state_d == STIM_HI);
            busy_q  <= (state_d == STIM_HI) || (state_d == STIM_LO) || (state_d == REFRACT);
            hitc_q  <= popcount8(8'(hist_d));
        end
    end

    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        win_d     = win_q;
        train_d   = train_q;
        gen_start = 1'b0;
        gen_abort = 1'b0;
        strobe    = win_valid & ~en;
        hit       = $signed(ws_in) >= THR;
        hist_new  = M_WIN'({hist_q, hit});
        unique case (state_q)
            WARMUP: begin
                if (WARMUP_WIN == 0) begin
                    state_d = IDLE;
                end else if (strobe) begin
                    if (win_q == WARM_LAST) begin
                        state_d = IDLE;
                        win_d   = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
            end
            IDLE: begin
                if (strobe) begin
                    if (popcount8(8'(hist_new)) >= 4'(K_HITS)) begin
                        state_d   = STIM_HI;
                        hist_d    = '0;
                        gen_start = 1'b1;
                        if (train_q != '1) train_d = train_q + 1'b1;
                    end else begin
                        hist_d = hist_new;
                    end
                end
            end
            STIM_HI, STIM_LO: begin
                // Phase tracks the generator's look-ahead level so stimulation stays registered.
                if (en) begin
                    gen_abort = 1'b1;
                    state_d   = REFRACT;
                    win_d     = '0;
                end else if (gen_done) begin
                    state_d = REFRACT;
                    win_d   = '0;
                end else begin
                    state_d = gen_pulse ? STIM_HI : STIM_LO;
                end
            end
            REFRACT: begin
                if (REFRACT_WIN == 0) begin
                    state_d = IDLE;
                    hist_d  = '0;
                end else if (strobe) begin
                    if (win_q == REFR_LAST) begin
                        state_d = IDLE;
                        win_d   = '0;
                        hist_d  = '0;
                    end else begin
                        win_d = win_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = WARMUP;
                win_d   = '0;
                hist_d  = '0;
            end
        endcase
    end

    assign stimulation = stim_q;
    assign busy        = busy_q;
    assign state_out   = state_q;
    assign hit_count   = hitc_q;
    assign train_count = train_q;

endmodule

// File: tb/tb_stim_scheduler.sv
// Directed test-plan walk plus randomized windows, checked each cycle against
// a timeline model (windows remaining, train offset, history queue).
module tb_stim_scheduler;

    localparam int SUM_W       = 12;
    localparam int THRESHOLD   = 300;
    localparam int M_WIN       = 4;
    localparam int K_HITS      = 3;
    localparam int WARMUP_WIN  = 8;
    localparam int PULSE_HI    = 4;
    localparam int PULSE_LO    = 6;
    localparam int NUM_PULSES  = 3;
    localparam int REFRACT_WIN = 5;
    localparam int PERIOD      = PULSE_HI + PULSE_LO;
    localparam int TRAIN_LEN   = NUM_PULSES * PERIOD;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             win_valid;
    logic [SUM_W-1:0] ws_in;
    logic             stimulation;
    logic             busy;
    logic [2:0]       state_out;
    logic [3:0]       hit_count;
    logic [15:0]      train_count;

    int vectors = 0;
    int miscompares = 0;

    // reference timeline
    int warm_left, refr_left, t_off, trains;
    bit in_train;
    bit hist[$];

    stim_scheduler #(
        .SUM_W       (SUM_W),
        .THRESHOLD   (THRESHOLD),
        .M_WIN       (M_WIN),
        .K_HITS      (K_HITS),
        .WARMUP_WIN  (WARMUP_WIN),
        .PULSE_HI    (PULSE_HI),
        .PULSE_LO    (PULSE_LO),
        .NUM_PULSES  (NUM_PULSES),
        .REFRACT_WIN (REFRACT_WIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .win_valid   (win_valid),
        .ws_in       (ws_in),
        .stimulation (stimulation),
        .busy        (busy),
        .state_out   (state_out),
        .hit_count   (hit_count),
        .train_count (train_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        warm_left = WARMUP_WIN;
        refr_left = 0;
        t_off     = 0;
        trains    = 0;
        in_train  = 1'b0;
        hist.delete();
    endtask

    function automatic int hist_hits();
        int n = 0;
        foreach (hist[i]) n += int'(hist[i]);
        return n;
    endfunction

    task automatic model_edge(input bit e, input bit v, input int w);
        if (warm_left > 0) begin
            if (!e && v) warm_left--;
        end else if (in_train) begin
            if (e) begin
                in_train  = 1'b0;
                refr_left = REFRACT_WIN;
            end else begin
                t_off++;
                if (t_off == TRAIN_LEN) begin
                    in_train  = 1'b0;
                    refr_left = REFRACT_WIN;
                end
            end
        end else if (refr_left > 0) begin
            if (!e && v) refr_left--;
        end else if (!e && v) begin
            hist.push_back(w >= THRESHOLD);
            if (hist.size() > M_WIN) void'(hist.pop_front());
            if (hist_hits() >= K_HITS) begin
                in_train = 1'b1;
                t_off    = 0;
                hist.delete();
                if (trains < 65535) trains++;
            end
        end
    endtask

    task automatic check_all();
        int exp_state;
        bit exp_stim;
        exp_stim = in_train && ((t_off % PERIOD) < PULSE_HI);
        if (warm_left > 0)      exp_state = 0;
        else if (in_train)      exp_state = exp_stim ? 2 : 3;
        else if (refr_left > 0) exp_state = 4;
        else                    exp_state = 1;
        chk("stimulation", 32'(stimulation), 32'(exp_stim));
        chk("busy",        32'(busy),        32'(in_train || refr_left > 0));
        chk("state_out",   32'(state_out),   32'(exp_state));
        chk("hit_count",   32'(hit_count),   32'(hist_hits()));
        chk("train_count", 32'(train_count), 32'(trains));
    endtask

    // Drive one cycle's inputs, clock, advance the model, then sample #1 after the edge.
    task automatic step(input bit e, input bit v, input int w);
        en        = e;
        win_valid = v;
        ws_in     = SUM_W'(w);
        @(posedge clk);
        model_edge(e, v, w);
        #1;
        check_all();
    endtask

    task automatic warmup_seq();
        for (int i = 0; i < WARMUP_WIN; i++) begin
            step(1'b0, 1'b1, 400);
            chk("warmup_no_stim", 32'(stimulation), 32'd0);
            if (i != WARMUP_WIN - 1) step(1'b0, 1'b0, 0);
        end
        chk("warmup_state_idle", 32'(state_out), 32'd1);
        chk("warmup_hits_zero",  32'(hit_count), 32'd0);
    endtask

    initial begin
        int vote_ws[5];
        int w;
        vote_ws = '{400, 100, 350, 299, 300};
        rst = 1'b1;
        en = 1'b0;
        win_valid = 1'b0;
        ws_in = '0;
        model_reset();
        #1;
        chk("reset_stim",  32'(stimulation), 32'd0);
        chk("reset_state", 32'(state_out),   32'd0);
        chk("reset_busy",  32'(busy),        32'd0);
        chk("reset_hits",  32'(hit_count),   32'd0);
        chk("reset_train", 32'(train_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        warmup_seq();

        // vote: 1,0,1,0,1 never reaches 3 of the last 4; a further 400 does (1011)
        foreach (vote_ws[i]) begin
            step(1'b0, 1'b1, vote_ws[i]);
            chk("vote_no_trigger", 32'(stimulation), 32'd0);
            step(1'b0, 1'b0, 0);
        end
        chk("vote_hits_two", 32'(hit_count), 32'd2);
        step(1'b0, 1'b1, 400);
        chk("trigger_stim",  32'(stimulation), 32'd1);
        chk("trigger_train", 32'(train_count), 32'd1);
        chk("trigger_state", 32'(state_out),   32'd2);

        for (int i = 1; i < TRAIN_LEN; i++) begin
            step(1'b0, (i % 3) == 0, 400);
            chk("train_shape", 32'(stimulation), 32'((i % PERIOD) < PULSE_HI));
        end
        step(1'b0, 1'b0, 0);
        chk("train_end_state", 32'(state_out), 32'd4);
        chk("train_end_busy",  32'(busy),      32'd1);

        for (int i = 0; i < REFRACT_WIN; i++) begin
            chk("refract_state", 32'(state_out), 32'd4);
            step(1'b0, 1'b1, 500);
            chk("refract_no_stim", 32'(stimulation), 32'd0);
        end
        chk("refract_exit_idle", 32'(state_out), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 400);
        chk("retrigger_stim",  32'(stimulation), 32'd1);
        chk("retrigger_train", 32'(train_count), 32'd2);

        // abort during the second high phase
        for (int i = 0; i < PERIOD + 1; i++) step(1'b0, 1'b0, 0);
        chk("second_pulse_high", 32'(stimulation), 32'd1);
        step(1'b1, 1'b0, 0);
        chk("abort_stim",  32'(stimulation), 32'd0);
        chk("abort_state", 32'(state_out),   32'd4);
        chk("abort_train", 32'(train_count), 32'd2);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 500);
            chk("disabled_frozen", 32'(state_out), 32'd4);
        end
        for (int i = 0; i < REFRACT_WIN; i++) step(1'b0, 1'b1, 500);
        chk("post_abort_idle", 32'(state_out), 32'd1);

        // async reset in the middle of a high phase
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 400);
        step(1'b0, 1'b0, 0);
        step(1'b0, 1'b0, 0);
        chk("pre_reset_stim", 32'(stimulation), 32'd1);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_stim",  32'(stimulation), 32'd0);
        chk("async_reset_state", 32'(state_out),   32'd0);
        chk("async_reset_train", 32'(train_count), 32'd0);
        model_reset();
        #2 rst = 1'b0;
        warmup_seq();

        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 1) == 0) w = 250 + int'($urandom_range(0, 100));
            else                           w = int'($urandom_range(0, 4095)) - 2048;
            step($urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0, w);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
